// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and width helpers for the systolic-array feed logic.
//   feed_state_t : controller state encoding (IDLE / FEED / FLUSH_W / DONE)
//   t_width()    : width of the skew step counter for a given N and KMAX
package dsp_sys_arr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FEED    = 2'd1,
    FLUSH_W = 2'd2,
    DONE    = 2'd3
  } feed_state_t;

  // The step counter must reach N-1+KMAX-1, so N+KMAX plus one bit of headroom.
  function automatic int t_width(input int n, input int kmax);
    return $clog2(n + kmax) + 1;
  endfunction

  localparam int N_DEF    = 4;
  localparam int KMAX_DEF = 16;
  localparam int T_W_DEF  = t_width(N_DEF, KMAX_DEF);

endpackage

// File: rtl/sys_arr_feed_ctrl_skew_mask_gen.sv
// skew_mask_gen: diagonal schedule window.
//   t     : current skew step
//   k_reg : elements per row in this tile
//   sched : bit r set when r <= t < r + k_reg
module skew_mask_gen #(
  parameter int N   = 4,
  parameter int T_W = 6,
  parameter int K_W = 5
) (
  input  logic [T_W-1:0] t,
  input  logic [K_W-1:0] k_reg,
  output logic [N-1:0]   sched
);

  // One extra bit so r + k_reg cannot wrap in the upper-bound compare.
  localparam int XW = T_W + 1;

  logic [XW-1:0] t_x_s;
  logic [XW-1:0] k_x_s;

  assign t_x_s = {1'b0, t};
  assign k_x_s = XW'(k_reg);

  // Per-row window compare, unsigned.
  always_comb begin
    sched = {N{1'b0}};
    for (int r = 0; r < N; r++) begin
      if ((t_x_s >= XW'(r)) && (t_x_s < (XW'(r) + k_x_s))) begin
        sched[r] = 1'b1;
      end else begin
        sched[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sys_arr_feed_ctrl.sv
// sys_arr_feed_ctrl: skew scheduler feeding an N-row systolic array from N
// row FIFOs. Row r starts popping r cycles after row 0; any scheduled row
// whose FIFO is empty stalls every row so the diagonal skew is kept. After
// the last pop it waits FLUSH cycles for the array to drain, then pulses done.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle tile request (ignored while busy)
//   k_len      : elements per row, sampled on an accepted start (saturated to KMAX)
//   fifo_empty : per-row FIFO empty flags
//   fifo_pop   : per-row pop, combinational from state and step counter
//   row_en     : fifo_pop delayed one cycle
//   stall      : FEED blocked by an empty scheduled row
//   busy       : not IDLE
//   done       : one-cycle completion pulse
module sys_arr_feed_ctrl
  import dsp_sys_arr_pkg::*;
#(
  parameter int N     = 4,
  parameter int KMAX  = 16,
  parameter int FLUSH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(KMAX):0]     k_len,
  input  logic [N-1:0]              fifo_empty,
  output logic [N-1:0]              fifo_pop,
  output logic [N-1:0]              row_en,
  output logic                      stall,
  output logic                      busy,
  output logic                      done
);

  localparam int K_W = $clog2(KMAX) + 1;
  localparam int T_W = t_width(N, KMAX);
  localparam int F_W = $clog2(FLUSH) + 1;
  localparam int XW  = T_W + 1;

  feed_state_t    state_r, state_nxt_s;
  logic [T_W-1:0] t_r, t_nxt_s;
  logic [K_W-1:0] k_r, k_nxt_s;
  logic [F_W-1:0] fc_r, fc_nxt_s;
  logic [N-1:0]   row_en_r;
  logic [N-1:0]   sched_s;
  logic [K_W-1:0] k_sat_s;
  logic           blk_s;
  logic           last_s;

  skew_mask_gen #(
    .N   (N),
    .T_W (T_W),
    .K_W (K_W)
  ) u_skew_mask_gen (
    .t     (t_r),
    .k_reg (k_r),
    .sched (sched_s)
  );

  assign k_sat_s = (k_len > K_W'(KMAX)) ? K_W'(KMAX) : k_len;
  assign blk_s   = |(sched_s & fifo_empty);
  // Last pop step is t = N-1+k-1, written as t+2 == N+k to stay unsigned.
  assign last_s  = (({1'b0, t_r} + XW'(2)) == (XW'(N) + XW'(k_r)));

  assign row_en = row_en_r;
  assign busy   = (state_r != IDLE);
  assign done   = (state_r == DONE);

  // Next-state, counter and pop/stall decode.
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    k_nxt_s     = k_r;
    fc_nxt_s    = fc_r;
    fifo_pop    = {N{1'b0}};
    stall       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (k_sat_s == K_W'(0)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = FEED;
            k_nxt_s     = k_sat_s;
            t_nxt_s     = {T_W{1'b0}};
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FEED: begin
        if (blk_s) begin
          // All-or-nothing: no row advances, so the skew stays intact.
          stall = 1'b1;
        end else begin
          fifo_pop = sched_s;
          if (last_s) begin
            state_nxt_s = FLUSH_W;
            fc_nxt_s    = {F_W{1'b0}};
          end else begin
            t_nxt_s = t_r + T_W'(1);
          end
        end
      end
      FLUSH_W: begin
        if (fc_r == F_W'(FLUSH - 1)) begin
          state_nxt_s = DONE;
        end else begin
          fc_nxt_s = fc_r + F_W'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and row_en pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      t_r      <= {T_W{1'b0}};
      k_r      <= {K_W{1'b0}};
      fc_r     <= {F_W{1'b0}};
      row_en_r <= {N{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      t_r      <= t_nxt_s;
      k_r      <= k_nxt_s;
      fc_r     <= fc_nxt_s;
      row_en_r <= fifo_pop;
    end
  end

endmodule

// File: tb/tb_sys_arr_feed_ctrl.sv
module tb_sys_arr_feed_ctrl;

  localparam int N     = 4;
  localparam int KMAX  = 16;
  localparam int FLUSH = 8;
  localparam int K_W   = $clog2(KMAX) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [K_W-1:0] k_len;
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   fifo_pop;
  logic [N-1:0]   row_en;
  logic           stall;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  sys_arr_feed_ctrl #(.N(N), .KMAX(KMAX), .FLUSH(FLUSH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .row_en     (row_en),
    .stall      (stall),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0 idle, 1 feeding, 2 flushing, 3 done.
  int           m_mode = 0;
  int           m_step = 0;
  int           m_k    = 0;
  int           m_fl   = 0;
  logic [N-1:0] m_prev_pop = '0;
  bit           cmp_en = 1'b0;

  // Observation logs for the per-scenario literal checks.
  logic [N-1:0] pop_log[$];
  logic [N-1:0] ren_log[$];
  int row_cnt[N];
  int busy_cyc, done_cnt, stall_cnt, last_pop_cyc, done_cyc;
  int cyc = 0;

  task automatic clear_logs();
    pop_log.delete();
    ren_log.delete();
    for (int r = 0; r < N; r++) row_cnt[r] = 0;
    busy_cyc = 0; done_cnt = 0; stall_cnt = 0; last_pop_cyc = 0; done_cyc = 0;
  endtask

  // Compare DUT against the model every cycle, log, then advance the model.
  always @(negedge clk) begin
    logic [N-1:0] e_sched;
    logic [N-1:0] e_pop;
    bit           e_blk;
    cyc++;
    if (cmp_en) begin
      e_sched = '0;
      for (int r = 0; r < N; r++)
        if (m_mode == 1 && m_step >= r && m_step < r + m_k) e_sched[r] = 1'b1;
      e_blk = |(e_sched & fifo_empty);
      e_pop = e_blk ? '0 : e_sched;
      check("fifo_pop", 32'(fifo_pop), 32'(e_pop));
      check("row_en", 32'(row_en), 32'(m_prev_pop));
      check("stall", 32'(stall), 32'(m_mode == 1 && e_blk));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_mode == 3));
      check("pop_on_empty", 32'(fifo_pop & fifo_empty), 32'd0);

      if (fifo_pop != '0) begin pop_log.push_back(fifo_pop); last_pop_cyc = cyc; end
      if (row_en != '0) ren_log.push_back(row_en);
      for (int r = 0; r < N; r++) row_cnt[r] += int'(fifo_pop[r]);
      if (busy) busy_cyc++;
      if (stall) stall_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end

      if (rst) begin
        m_mode = 0; m_step = 0; m_prev_pop = '0;
      end else begin
        m_prev_pop = e_pop;
        case (m_mode)
          0: if (start) begin
               m_k = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
               if (m_k == 0) m_mode = 3;
               else begin m_mode = 1; m_step = 0; end
             end
          1: if (!e_blk) begin
               m_step++;
               if (m_step == N + m_k - 1) begin m_mode = 2; m_fl = 0; end
             end
          2: begin m_fl++; if (m_fl == FLUSH) m_mode = 3; end
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic run_start(input int k);
    @(posedge clk); #1;
    start = 1'b1; k_len = K_W'(k);
    @(posedge clk); #1;
    start = 1'b0; k_len = '0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_done_timeout: got no done expected done within 200 cycles", tag);
    end
    @(posedge clk); #1;
  endtask

  // Hand-computed expectations for a clean k=3 tile.
  task automatic check_k3(input string tag, input int stalls);
    logic [N-1:0] e[6];
    e = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    check({tag, "_pop_count"}, 32'(pop_log.size()), 32'd6);
    check({tag, "_ren_count"}, 32'(ren_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < pop_log.size()) check({tag, "_pop_seq"}, 32'(pop_log[i]), 32'(e[i]));
      if (i < ren_log.size()) check({tag, "_ren_seq"}, 32'(ren_log[i]), 32'(e[i]));
    end
    for (int r = 0; r < N; r++) check({tag, "_row_pops"}, 32'(row_cnt[r]), 32'd3);
    check({tag, "_done_lat"}, 32'(done_cyc - last_pop_cyc), 32'(FLUSH + 1));
    check({tag, "_busy_cyc"}, 32'(busy_cyc), 32'(15 + stalls));
    check({tag, "_stalls"}, 32'(stall_cnt), 32'(stalls));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; fifo_empty = '0;
    clear_logs();
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({fifo_pop, row_en, stall, busy, done}), 32'd0);

    // 1: basic k=3 tile
    clear_logs();
    run_start(3);
    wait_done("s1");
    check_k3("s1", 0);

    // 2: row 2 empty during the third FEED cycle
    clear_logs();
    run_start(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_empty = 4'b0100;
    @(posedge clk); #1;
    fifo_empty = 4'b0000;
    wait_done("s2");
    check_k3("s2", 1);

    // 3: zero-length tile
    clear_logs();
    run_start(0);
    wait_done("s3");
    check("s3_pop_count", 32'(pop_log.size()), 32'd0);
    check("s3_busy_cyc", 32'(busy_cyc), 32'd1);
    check("s3_done_cnt", 32'(done_cnt), 32'd1);

    // 4: start mid-FEED is ignored
    clear_logs();
    run_start(3);
    start = 1'b1; k_len = K_W'(5);
    @(posedge clk); #1;
    start = 1'b0; k_len = '0;
    wait_done("s4");
    check_k3("s4", 0);

    // 5: reset in the 4th FEED cycle, then a clean tile
    clear_logs();
    run_start(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s5_after_reset", 32'({fifo_pop, row_en, stall, busy, done}), 32'd0);
    clear_logs();
    run_start(3);
    wait_done("s5");
    check_k3("s5", 0);

    // 6: k_len above KMAX saturates, with intermittent empties
    clear_logs();
    run_start(KMAX + 5);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
      fifo_empty = (i % 5 == 2) ? 4'b0100 : ((i % 7 == 3) ? 4'b0001 : 4'b0000);
    end
    fifo_empty = '0;
    check("s6_done_cnt", 32'(done_cnt), 32'd1);
    for (int r = 0; r < N; r++) check("s6_row_pops", 32'(row_cnt[r]), 32'(KMAX));
    @(posedge clk); #1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_arr_feed_ctrl.md
Name: sys_arr_feed_ctrl

Overview:
Skew scheduler that feeds an N-row systolic array from N per-row FIFOs, each on a FIFO_if master modport. It issues staggered (diagonal) pops so that row r starts r cycles after row 0, and stalls all rows together when any scheduled row's FIFO is empty. It then waits for the array to flush and pulses done. It sits between the row input FIFOs and the array's row-enable inputs.

Parameters:
N, 4, number of array rows / input FIFOs
KMAX, 16, maximum vector length per tile
FLUSH, 8, drain cycles after the last pop (array pipeline depth)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a tile
k_len  input  $clog2(KMAX)+1  elements per row for this tile, sampled on an accepted start
fifo_empty  input  N  is_empty from each row FIFO
fifo_pop  output  N  pop to each row FIFO (combinational from state and counter)
row_en  output  N  fifo_pop registered one cycle; qualifies dat_out captured into the array row
stall  output  1  high in FEED when scheduled rows are blocked
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at tile completion

Behaviour:
- One clock; reset is synchronous and active-high, ports clk/rst. On reset: state=IDLE, t=0, k_reg=0, fifo_pop=0, row_en=0, stall=0, busy=0, done=0.
- States: IDLE, FEED, FLUSH_W, DONE.
- IDLE:
  - start=1 with k_len>0 -> k_reg<=k_len, t<=0, go to FEED.
  - start=1 with k_len=0 -> go directly to DONE; no pops are issued.
  - start while busy is ignored.
- FEED, schedule:
  - Row r is scheduled when r <= t < r+k_reg.
  - sched[N] is the scheduled mask; blk = |(sched & fifo_empty).
  - If blk=0: fifo_pop=sched, t<=t+1.
  - If blk=1: fifo_pop=0, stall=1, t holds. This is an all-or-nothing stall that preserves the diagonal skew.
- FEED, exit:
  - The last pop happens when t = N-1+k_reg-1.
  - After that cycle (unstalled), go to FLUSH_W and set the flush counter fc<=0.
  - Total unstalled FEED cycles = N+k_reg-1.
- FLUSH_W: fc increments each cycle. At fc=FLUSH-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- row_en[r] = fifo_pop[r] delayed one cycle. row_en is cleared on reset; pops and row_en are never generated outside FEED.
- The array consumes FIFO dat_out in the pop cycle. The controller itself never touches data.
- Widths:
  - t is $clog2(N+KMAX)+1 bits; comparisons are unsigned.
  - k_len > KMAX is saturated to KMAX at sampling.
- Reset mid-operation: immediate return to IDLE with all outputs 0. FIFO contents are not the controller's concern.
- A FIFO going empty mid-row only stalls; a pop is never issued to an empty FIFO (pop&is_empty is never high).

Decomposition:
- dsp_sys_arr_pkg gains feed_state_t (enum IDLE/FEED/FLUSH_W/DONE) and a localparam for the t counter width helper.
- Sub-module skew_mask_gen (inputs t, k_reg; output sched[N]): combinational window compare, instanced once and unit-testable alone.

Test Plan:
1. N=4, k_len=3, all fifo_empty=0, start pulse -> FEED lasts 6 cycles. fifo_pop per cycle: 0001, 0011, 0111, 1110, 1100, 1000. row_en is the same sequence one cycle later. done pulses FLUSH+1 cycles after the last pop; busy is high from start+1 through done.
2. Same setup, fifo_empty[2]=1 during the third FEED cycle only -> that cycle has fifo_pop=0000 and stall=1, then the pattern resumes at 0111. FEED is 7 cycles; total pops per row = 3.
3. start with k_len=0 -> next cycle done=1, fifo_pop never asserted, back in IDLE after that.
4. Second start pulse issued mid-FEED -> ignored; pop pattern and done timing identical to scenario 1.
5. rst asserted in the 4th FEED cycle -> next cycle all outputs 0, state IDLE. A fresh start then reproduces scenario 1 exactly.
6. k_len=KMAX+5 -> treated as KMAX: each row popped exactly 16 times, and the assertion pop&fifo_empty==0 holds throughout.
